riscv_mc_control_unit: RTL

//  Multi-cycle FSM controller for the RV32I datapath (register file, ALU, imm-extend, PC adders/muxes).

---
 rtl/riscv_mc_control_unit.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mc_control_unit.sv
// Multi-cycle RV32I controller: FETCH -> DECODE -> EXECUTE (-> MEM) sequencing with
// a latched instruction register, decoded datapath controls and a bus ready handshake.
module riscv_mc_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        irEn,
  output logic        pcEn,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        JAL,
  output logic        JALR,
  output logic        busReq,
  output logic        busWe,
  output logic        illegalInstr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_L,
    C_S,
    C_B,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_ILLEGAL
  } iclass_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_run;
  logic [6:0]  r_ir_opcode;
  logic [2:0]  r_ir_funct3;
  logic        r_ir_funct7b5;

  iclass_t     w_class;
  logic        w_alu_src;
  logic [3:0]  w_alu_ctrl;
  logic [2:0]  w_rfwd_sel;
  logic        w_writes_rd;
  logic        w_is_mem;

  logic        w_ir_en;
  logic        w_pc_en;
  logic        w_rf_we;
  logic        w_drive_dec;
  logic        w_branch;
  logic        w_jal;
  logic        w_jalr;
  logic        w_bus_req;
  logic        w_bus_we;
  logic        w_illegal;

  // Only opcode, funct3 and funct7[5] steer control; the rest belongs to the datapath.
  logic        w_unused_ir_bits;
  assign w_unused_ir_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // r_run releases one edge after reset_n rises, so reset removal is seen synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else if (r_run) begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_opcode   <= 7'd0;
      r_ir_funct3   <= 3'd0;
      r_ir_funct7b5 <= 1'b0;
    end else if (irEn) begin
      r_ir_opcode   <= instrCode[6:0];
      r_ir_funct3   <= instrCode[14:12];
      r_ir_funct7b5 <= instrCode[30];
    end
  end

  always_comb begin
    w_class = C_ILLEGAL;
    case (r_ir_opcode)
      OP_R:     w_class = C_R;
      OP_I:     w_class = C_I;
      OP_L:     w_class = C_L;
      OP_S:     w_class = C_S;
      OP_B:     w_class = C_B;
      OP_LUI:   w_class = C_LUI;
      OP_AUIPC: w_class = C_AUIPC;
      OP_JAL:   w_class = C_JAL;
      OP_JALR:  w_class = C_JALR;
      default:  w_class = C_ILLEGAL;
    endcase
  end

  always_comb begin
    w_alu_src   = 1'b0;
    w_alu_ctrl  = 4'b0000;
    w_rfwd_sel  = 3'd0;
    w_writes_rd = 1'b0;
    w_is_mem    = 1'b0;
    case (w_class)
      C_R: begin
        w_alu_ctrl  = {r_ir_funct7b5, r_ir_funct3};
        w_writes_rd = 1'b1;
      end
      C_I: begin
        // funct7[5] only distinguishes srai from srli; addi's imm[10] must not select SUB.
        w_alu_src   = 1'b1;
        w_alu_ctrl  = {(r_ir_funct3 == 3'b101) ? r_ir_funct7b5 : 1'b0, r_ir_funct3};
        w_writes_rd = 1'b1;
      end
      C_L: begin
        w_alu_src   = 1'b1;
        w_rfwd_sel  = 3'd1;
        w_writes_rd = 1'b1;
        w_is_mem    = 1'b1;
      end
      C_S: begin
        w_alu_src = 1'b1;
        w_is_mem  = 1'b1;
      end
      C_B: begin
        w_alu_ctrl = {1'b0, r_ir_funct3};
      end
      C_LUI: begin
        w_rfwd_sel  = 3'd3;
        w_writes_rd = 1'b1;
      end
      C_AUIPC: begin
        w_rfwd_sel  = 3'd4;
        w_writes_rd = 1'b1;
      end
      C_JAL: begin
        w_rfwd_sel  = 3'd2;
        w_writes_rd = 1'b1;
      end
      C_JALR: begin
        w_alu_src   = 1'b1;
        w_rfwd_sel  = 3'd2;
        w_writes_rd = 1'b1;
      end
      default: begin
        w_alu_src = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_en      = 1'b0;
    w_pc_en      = 1'b0;
    w_rf_we      = 1'b0;
    w_drive_dec  = 1'b0;
    w_branch     = 1'b0;
    w_jal        = 1'b0;
    w_jalr       = 1'b0;
    w_bus_req    = 1'b0;
    w_bus_we     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_class == C_ILLEGAL) begin
          w_illegal    = 1'b1;
          w_pc_en      = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_drive_dec  = 1'b1;
          w_state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_drive_dec = 1'b1;
        if (w_is_mem) begin
          w_state_next = S_MEM;
        end else begin
          w_pc_en      = 1'b1;
          w_rf_we      = w_writes_rd;
          w_branch     = (w_class == C_B);
          w_jal        = (w_class == C_JAL);
          w_jalr       = (w_class == C_JALR);
          w_state_next = S_FETCH;
        end
      end
      S_MEM: begin
        w_drive_dec = 1'b1;
        w_bus_req   = 1'b1;
        w_bus_we    = (w_class == C_S);
        if (busReady) begin
          w_pc_en      = 1'b1;
          w_rf_we      = (w_class == C_L);
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Gating with r_run makes every output fall to 0 the instant reset_n is asserted.
  assign irEn          = r_run & w_ir_en;
  assign pcEn          = r_run & w_pc_en;
  assign regFileWe     = r_run & w_rf_we;
  assign aluSrcMuxSel  = r_run & w_drive_dec & w_alu_src;
  assign aluControl    = {4{r_run & w_drive_dec}} & w_alu_ctrl;
  assign RFWDSrcMuxSel = {3{r_run & w_drive_dec}} & w_rfwd_sel;
  assign branch        = r_run & w_branch;
  assign JAL           = r_run & w_jal;
  assign JALR          = r_run & w_jalr;
  assign busReq        = r_run & w_bus_req;
  assign busWe         = r_run & w_bus_we;
  assign illegalInstr  = r_run & w_illegal;

endmodule
